sfifo_fwft: RTL and testbench

- Parameterized single-clock synchronous FIFO with first-word fall-through output.
- The head entry appears on dout whenever the FIFO is non-empty; no read latency.
- Used as the generic hop/meta/packet staging buffer in the path parser and similar datapath blocks.
- DEPTH_NBITS=0 gives the single-entry (1-deep) variant, so one module covers both the multi-entry and 1-entry uses.

---
 rtl/sfifo_fwft.sv | 120 ++++++++++++
 tb/tb_sfifo_fwft.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/sfifo_fwft.sv
// ----------------------------------------------------------------------------
// sfifo_fwft: single-clock synchronous FIFO with first-word fall-through.
//
// The head entry is driven on o_dout combinationally whenever the FIFO is
// non-empty, so a reader sees data with no read latency and i_rd simply
// acknowledges (pops) the word currently shown.
//
// Parameters
//   WIDTH        data width in bits (>= 1)
//   DEPTH_NBITS  log2 of depth; DEPTH = 2**DEPTH_NBITS, 0 gives a 1-entry FIFO
//
// Ports
//   i_clk      clock, rising edge
//   i_rst      synchronous active-high reset
//   i_din      write data
//   i_wr       write strobe
//   i_rd       read/pop strobe, acknowledges the entry on o_dout
//   o_dout     head entry, valid when o_empty = 0
//   o_count    registered occupancy
//   o_ncount   occupancy after the coming edge (combinational)
//   o_full     count == DEPTH
//   o_fullm1   count >= DEPTH-1
//   o_empty    count == 0
//   o_emptyp2  count <= 2
//
// Optional macro SFIFO_CHECK_EN: adds simulation-only messages on overflow
// (wr & full & ~rd) and underflow (rd & empty) attempts. Behaviour is the
// same with or without it.
// ----------------------------------------------------------------------------
module sfifo_fwft #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned DEPTH_NBITS = 2
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [WIDTH-1:0]       i_din,
    input  logic                   i_wr,
    input  logic                   i_rd,
    output logic [WIDTH-1:0]       o_dout,
    output logic [DEPTH_NBITS:0]   o_count,
    output logic [DEPTH_NBITS:0]   o_ncount,
    output logic                   o_full,
    output logic                   o_fullm1,
    output logic                   o_empty,
    output logic                   o_emptyp2
);

    localparam int unsigned DEPTH = 1 << DEPTH_NBITS;
    localparam int unsigned CW    = DEPTH_NBITS + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [CW-1:0]    r_count;
    logic             w_rd_eff;
    logic             w_wr_eff;
    logic [CW-1:0]    w_ncount;

    // A read on empty is ignored; a write on full only lands if a pop frees a slot.
    assign w_rd_eff = i_rd & ~o_empty;
    assign w_wr_eff = i_wr & (~o_full | w_rd_eff);
    assign w_ncount = r_count + CW'(w_wr_eff) - CW'(w_rd_eff);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count <= '0;
        end else begin
            r_count <= w_ncount;
        end
    end

    if (DEPTH_NBITS > 0) begin : g_ptr
        logic [DEPTH_NBITS-1:0] r_wptr;
        logic [DEPTH_NBITS-1:0] r_rptr;

        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                r_wptr <= '0;
                r_rptr <= '0;
            end else begin
                if (w_wr_eff) r_wptr <= r_wptr + DEPTH_NBITS'(1);
                if (w_rd_eff) r_rptr <= r_rptr + DEPTH_NBITS'(1);
            end
        end

        // Storage is not reset; gating with i_rst keeps reset from touching it.
        always_ff @(posedge i_clk) begin
            if (!i_rst && w_wr_eff) r_mem[r_wptr] <= i_din;
        end

        assign o_dout = r_mem[r_rptr];
    end else begin : g_single
        // One entry: no pointers, the single slot is both head and tail.
        always_ff @(posedge i_clk) begin
            if (!i_rst && w_wr_eff) r_mem[0] <= i_din;
        end

        assign o_dout = r_mem[0];
    end

    // Flags decode the registered count only, so they lag the strobe by one edge.
    assign o_count   = r_count;
    assign o_ncount  = w_ncount;
    assign o_full    = (r_count == CW'(DEPTH));
    assign o_fullm1  = (r_count >= CW'(DEPTH - 1));
    assign o_empty   = (r_count == '0);
    assign o_emptyp2 = (32'(r_count) <= 32'd2);

`ifdef SFIFO_CHECK_EN
`ifndef SYNTHESIS
    always @(posedge i_clk) begin
        if (!i_rst && i_wr && o_full && !i_rd) begin
            $display("%0t %m: sfifo overflow attempt, write dropped", $time);
        end
        if (!i_rst && i_rd && o_empty) begin
            $display("%0t %m: sfifo underflow attempt, read ignored", $time);
        end
    end
`endif
`endif

endmodule

// File: tb/tb_sfifo_fwft.sv
// ----------------------------------------------------------------------------
// tb_sfifo_fwft: self-checking bench for sfifo_fwft.
// Runs a 4-deep and a 1-deep instance side by side against queue-based
// reference models, with directed scenarios followed by random traffic.
// ----------------------------------------------------------------------------
module tb_sfifo_fwft;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] din_a, din_b;
    logic       wr_a, rd_a, wr_b, rd_b;

    logic [7:0] dout_a, dout_b;
    logic [2:0] count_a, ncount_a;
    logic [0:0] count_b, ncount_b;
    logic       full_a, fullm1_a, empty_a, emptyp2_a;
    logic       full_b, fullm1_b, empty_b, emptyp2_b;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    int unsigned q_a[$];
    int unsigned q_b[$];

    always #5 clk = ~clk;

    sfifo_fwft #(.WIDTH(8), .DEPTH_NBITS(2)) u_dut_a (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_din     (din_a),
        .i_wr      (wr_a),
        .i_rd      (rd_a),
        .o_dout    (dout_a),
        .o_count   (count_a),
        .o_ncount  (ncount_a),
        .o_full    (full_a),
        .o_fullm1  (fullm1_a),
        .o_empty   (empty_a),
        .o_emptyp2 (emptyp2_a)
    );

    sfifo_fwft #(.WIDTH(8), .DEPTH_NBITS(0)) u_dut_b (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_din     (din_b),
        .i_wr      (wr_b),
        .i_rd      (rd_b),
        .o_dout    (dout_b),
        .o_count   (count_b),
        .o_ncount  (ncount_b),
        .o_full    (full_b),
        .o_fullm1  (fullm1_b),
        .o_empty   (empty_b),
        .o_emptyp2 (emptyp2_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Compare every registered output against the models' occupancy and head.
    task automatic check_outputs();
        int unsigned sa;
        int unsigned sb;
        sa = q_a.size();
        sb = q_b.size();
        check("count_a",   32'(count_a),   sa);
        check("empty_a",   32'(empty_a),   32'(sa == 0));
        check("full_a",    32'(full_a),    32'(sa == 4));
        check("fullm1_a",  32'(fullm1_a),  32'(sa >= 3));
        check("emptyp2_a", 32'(emptyp2_a), 32'(sa <= 2));
        if (sa > 0) check("dout_a", 32'(dout_a), q_a[0]);
        check("count_b",   32'(count_b),   sb);
        check("empty_b",   32'(empty_b),   32'(sb == 0));
        check("full_b",    32'(full_b),    32'(sb == 1));
        check("fullm1_b",  32'(fullm1_b),  32'd1);
        check("emptyp2_b", 32'(emptyp2_b), 32'd1);
        if (sb > 0) check("dout_b", 32'(dout_b), q_b[0]);
    endtask

    // One clock: drive both DUTs, check ncount, advance models, check outputs.
    task automatic step(input logic r,
                        input logic wa, input logic ra, input logic [7:0] da,
                        input logic wb, input logic rb, input logic [7:0] db);
        bit ra_ok, wa_ok, rb_ok, wb_ok;
        rst   = r;
        wr_a  = wa;
        rd_a  = ra;
        din_a = da;
        wr_b  = wb;
        rd_b  = rb;
        din_b = db;
        #1;
        ra_ok = ra && (q_a.size() > 0);
        wa_ok = wa && ((q_a.size() < 4) || ra_ok);
        rb_ok = rb && (q_b.size() > 0);
        wb_ok = wb && ((q_b.size() < 1) || rb_ok);
        if (!r) begin
            check("ncount_a", 32'(ncount_a), q_a.size() + 32'(wa_ok) - 32'(ra_ok));
            check("ncount_b", 32'(ncount_b), q_b.size() + 32'(wb_ok) - 32'(rb_ok));
        end
        @(posedge clk);
        if (r) begin
            q_a.delete();
            q_b.delete();
        end else begin
            if (ra_ok) void'(q_a.pop_front());
            if (wa_ok) q_a.push_back(32'(da));
            if (rb_ok) void'(q_b.pop_front());
            if (wb_ok) q_b.push_back(32'(db));
        end
        #1;
        check_outputs();
    endtask

    task automatic step_a(input logic wa, input logic ra, input logic [7:0] da);
        step(1'b0, wa, ra, da, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic step_b(input logic wb, input logic rb, input logic [7:0] db);
        step(1'b0, 1'b0, 1'b0, 8'h00, wb, rb, db);
    endtask

    initial begin
        rst = 1'b1;
        {wr_a, rd_a, wr_b, rd_b} = '0;
        din_a = '0;
        din_b = '0;

        // Reset, then idle.
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        check("rst_fullm1_a", 32'(fullm1_a), 32'd0);

        // Fill the 4-deep FIFO.
        step_a(1'b1, 1'b0, 8'h11);
        check("first_dout_a", 32'(dout_a), 32'h11);
        step_a(1'b1, 1'b0, 8'h22);
        step_a(1'b1, 1'b0, 8'h33);
        check("fullm1_at3", 32'(fullm1_a), 32'd1);
        step_a(1'b1, 1'b0, 8'h44);
        check("full_at4", 32'(full_a), 32'd1);

        // Write on full is dropped; read+write on full is accepted.
        step_a(1'b1, 1'b0, 8'h55);
        check("drop_count", 32'(count_a), 32'd4);
        step_a(1'b1, 1'b1, 8'h66);
        check("rdwr_full_count", 32'(count_a), 32'd4);
        check("rdwr_full_dout", 32'(dout_a), 32'h22);
        for (int i = 0; i < 4; i++) step_a(1'b0, 1'b1, 8'h00);

        // Read on empty is ignored; read+write on empty stores the word.
        step_a(1'b0, 1'b1, 8'h00);
        check("rd_empty_count", 32'(count_a), 32'd0);
        step_a(1'b1, 1'b1, 8'hA5);
        check("rdwr_empty_dout", 32'(dout_a), 32'hA5);
        step_a(1'b0, 1'b1, 8'h00);

        // Single-entry instance.
        step_b(1'b1, 1'b0, 8'h07);
        check("b_first_dout", 32'(dout_b), 32'h07);
        step_b(1'b1, 1'b0, 8'h08);
        check("b_drop_dout", 32'(dout_b), 32'h07);
        step_b(1'b1, 1'b1, 8'h09);
        check("b_rdwr_dout", 32'(dout_b), 32'h09);
        step_b(1'b0, 1'b1, 8'h00);

        // Interleaved traffic wrapping the pointers, then reset at count 3.
        for (int i = 0; i < 10; i++) step_a(1'b1, (i > 0), 8'(8'h80 + i));
        step_a(1'b1, 1'b0, 8'h90);
        step_a(1'b1, 1'b0, 8'h91);
        check("pre_rst_count", 32'(count_a), 32'd3);
        step(1'b1, 1'b1, 1'b0, 8'hEE, 1'b1, 1'b0, 8'hEE);
        check("post_rst_count", 32'(count_a), 32'd0);
        step_a(1'b1, 1'b0, 8'hC3);
        check("post_rst_dout", 32'(dout_a), 32'hC3);

        // Random traffic with phases biased toward filling and draining.
        for (int i = 0; i < 3000; i++) begin
            bit fill;
            fill = ((i / 150) % 2) == 0;
            step(($urandom_range(99) == 0),
                 ($urandom_range(99) < (fill ? 75 : 35)),
                 ($urandom_range(99) < (fill ? 35 : 75)),
                 8'($urandom),
                 ($urandom_range(99) < 50),
                 ($urandom_range(99) < 50),
                 8'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
